// File: rtl/circuit_eval_pkg.sv
// ---------------------------------------------------------------------------
// circuit_eval_pkg
//   Shared definitions for the circuit evaluation sequencer: FSM state
//   encodings, stimulus mode encodings, the 32-bit LFSR tap mask and the
//   step functions for the LFSR and the rotate-XOR signature (MISR).
// ---------------------------------------------------------------------------
package circuit_eval_pkg;

  typedef logic [1:0] state_t;

  // Sequencer FSM states
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_SETTLE  = 2'd1;
  localparam state_t ST_CAPTURE = 2'd2;
  localparam state_t ST_DONE    = 2'd3;

  // Stimulus source selection
  localparam logic MODE_COUNTER = 1'b0;
  localparam logic MODE_LFSR    = 1'b1;

  // Fibonacci taps at bits 31, 21, 1 and 0
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // One LFSR shift: feedback is the parity of the tapped bits
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], ^(s & LFSR_TAPS)};
  endfunction

  // One MISR step over the low w bits: rotate left by one, XOR the response.
  // For w == 1 the rotate degenerates to the identity.
  function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                            input logic [31:0] resp,
                                            input int          w);
    logic [31:0] rot;
    logic [31:0] mask;
    rot  = 32'h0;
    mask = 32'h0;
    rot[0] = sig[w-1];
    for (int i = 1; i < 32; i++) begin
      if (i < w) begin
        rot[i] = sig[i-1];
      end
    end
    for (int j = 0; j < 32; j++) begin
      if (j < w) begin
        mask[j] = 1'b1;
      end
    end
    return (rot ^ resp) & mask;
  endfunction

endpackage

// File: rtl/circuit_eval_stim_gen.sv
// ---------------------------------------------------------------------------
// circuit_eval_stim_gen
//   Stimulus source for the sequencer: a W-bit wrapping counter or a 32-bit
//   Fibonacci LFSR whose low W bits form the vector.
// Ports
//   clk, rst   clock, asynchronous active-high reset
//   i_load     load the first vector from i_seed and latch i_mode
//   i_advance  step to the next vector
//   i_mode     0 = counter, 1 = LFSR (sampled only with i_load)
//   i_seed     first vector / LFSR seed (zero-extended to 32 bits)
//   o_vec      current vector, straight from the state register
// ---------------------------------------------------------------------------
module circuit_eval_stim_gen
  import circuit_eval_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_advance,
  input  logic         i_mode,
  input  logic [W-1:0] i_seed,
  output logic [W-1:0] o_vec
);

  logic [31:0] r_state;
  logic        r_mode;
  logic [31:0] w_seed_ext;
  logic [31:0] w_load_val;
  logic [31:0] w_adv_val;

  // Load value: zero-extended seed; an all-zero LFSR seed would lock up, so use 1
  always_comb begin
    w_seed_ext          = 32'h0;
    w_seed_ext[W-1:0]   = i_seed;
    if ((i_mode == MODE_LFSR) && (w_seed_ext == 32'h0)) begin
      w_load_val = 32'h1;
    end else begin
      w_load_val = w_seed_ext;
    end
  end

  // Next vector for the latched mode; the counter wraps silently at W bits
  always_comb begin
    w_adv_val = 32'h0;
    case (r_mode)
      MODE_COUNTER: w_adv_val[W-1:0] = r_state[W-1:0] + W'(1'b1);
      MODE_LFSR:    w_adv_val        = lfsr_next(r_state);
      default:      w_adv_val        = r_state;
    endcase
  end

  // Generator state and latched mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= 32'h0;
      r_mode  <= MODE_COUNTER;
    end else if (i_load) begin
      r_state <= w_load_val;
      r_mode  <= i_mode;
    end else if (i_advance) begin
      r_state <= w_adv_val;
      r_mode  <= r_mode;
    end else begin
      r_state <= r_state;
      r_mode  <= r_mode;
    end
  end

  assign o_vec = r_state[W-1:0];

endmodule

// File: rtl/circuit_eval_sequencer.sv
// ---------------------------------------------------------------------------
// circuit_eval_sequencer
//   Drives NUM_VECTORS stimulus vectors into a combinational circuit under
//   test, holds each for SETTLE_CYCLES cycles, then folds the response into
//   a rotate-XOR signature. The final signature and vector count summarise a
//   run as one word.
// Ports
//   clk, rst    clock, asynchronous active-high reset
//   start       begin a run (sampled in IDLE only)
//   abort       cancel a run in progress, no done pulse
//   mode        0 = counter stimulus, 1 = LFSR stimulus (sampled with start)
//   seed        first vector / LFSR seed (sampled with start)
//   dut_in      registered stimulus to the circuit under test
//   dut_out     circuit response
//   busy        high while settling or capturing
//   done        one-cycle pulse on normal completion
//   signature   MISR value, valid when done pulses
//   vec_count   vectors captured in the current/last run
// ---------------------------------------------------------------------------
module circuit_eval_sequencer
  import circuit_eval_pkg::*;
#(
  parameter  int IO_PAIRS      = 4,
  parameter  int SETTLE_CYCLES = 2,
  parameter  int NUM_VECTORS   = 16,
  localparam int W             = 2 * IO_PAIRS,
  localparam int CW            = $clog2(NUM_VECTORS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          mode,
  input  logic [W-1:0]  seed,
  output logic [W-1:0]  dut_in,
  input  logic [W-1:0]  dut_out,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  signature,
  output logic [CW-1:0] vec_count
);

  // settle counter runs 0 .. SETTLE_CYCLES-1
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_settle_cnt;
  logic [W-1:0]  r_signature;
  logic [CW-1:0] r_vec_count;
  logic          r_busy;
  logic          r_done;
  logic          w_load;
  logic          w_capture;
  logic          w_settle_last;
  logic          w_last_vec;
  logic [31:0]   w_sig_ext;
  logic [31:0]   w_resp_ext;
  logic [W-1:0]  w_sig_step;
  logic [W-1:0]  w_vec;

  assign w_settle_last = (r_settle_cnt == SW'(SETTLE_CYCLES - 1));
  assign w_last_vec    = (r_vec_count == CW'(NUM_VECTORS - 1));

  // Widen signature and response so the shared 32-bit MISR helper can be used
  always_comb begin
    w_sig_ext              = 32'h0;
    w_resp_ext             = 32'h0;
    w_sig_ext[W-1:0]       = r_signature;
    w_resp_ext[W-1:0]      = dut_out;
    w_sig_step             = W'(misr_step(w_sig_ext, w_resp_ext, W));
  end

  // Next state and per-cycle strobes; abort beats capture, start beats abort in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SETTLE;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_settle_last) begin
          w_state_nxt = ST_CAPTURE;
        end else begin
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_capture = 1'b1;
          if (w_last_vec) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_SETTLE;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register plus status flags registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_CAPTURE);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Settle counter: restarts for every vector, counts while settling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settle_cnt <= {SW{1'b0}};
    end else if (w_load || w_capture) begin
      r_settle_cnt <= {SW{1'b0}};
    end else if (r_state == ST_SETTLE) begin
      r_settle_cnt <= r_settle_cnt + SW'(1'b1);
    end else begin
      r_settle_cnt <= r_settle_cnt;
    end
  end

  // Signature and vector count: cleared by start, updated on capture, held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_signature <= {W{1'b0}};
      r_vec_count <= {CW{1'b0}};
    end else if (w_load) begin
      r_signature <= {W{1'b0}};
      r_vec_count <= {CW{1'b0}};
    end else if (w_capture) begin
      r_signature <= w_sig_step;
      r_vec_count <= r_vec_count + CW'(1'b1);
    end else begin
      r_signature <= r_signature;
      r_vec_count <= r_vec_count;
    end
  end

  circuit_eval_stim_gen #(
    .W (W)
  ) u_stim_gen (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_advance (w_capture),
    .i_mode    (mode),
    .i_seed    (seed),
    .o_vec     (w_vec)
  );

  assign dut_in    = w_vec;
  assign busy      = r_busy;
  assign done      = r_done;
  assign signature = r_signature;
  assign vec_count = r_vec_count;

endmodule

// File: tb/tb_circuit_eval_sequencer.sv
// ---------------------------------------------------------------------------
// tb_circuit_eval_sequencer
//   Bench for circuit_eval_sequencer driving a one-pair XOR/NOT circuit
//   (out[1] = in1 ^ in0, out[0] = ~in0). A main instance runs 4 vectors; a
//   second instance with 2 vectors covers the short counter-wrap run.
//   Expected captures are queued at start and popped by a monitor each time
//   vec_count advances.
// ---------------------------------------------------------------------------
module tb_circuit_eval_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       mode;
  logic [1:0] seed;

  logic [1:0] dut_in,  dut_out,  signature;
  logic       busy,    done;
  logic [2:0] vec_count;

  logic [1:0] dut_in2, dut_out2, signature2;
  logic       busy2,   done2;
  logic [1:0] vec_count2;

  int n_checks;
  int n_pass;

  typedef struct packed {
    logic [1:0] vec;
    logic [1:0] sig;
    logic [2:0] cnt;
  } exp_t;
  exp_t sb_q[$];

  int         lat2;
  logic [1:0] s2_first;
  logic [1:0] s2_second;
  logic [1:0] lfsr_sig_ref;

  assign dut_out  = {dut_in[1]  ^ dut_in[0],  ~dut_in[0]};
  assign dut_out2 = {dut_in2[1] ^ dut_in2[0], ~dut_in2[0]};

  circuit_eval_sequencer #(
    .IO_PAIRS(1), .SETTLE_CYCLES(2), .NUM_VECTORS(4)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .seed(seed),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
    .signature(signature), .vec_count(vec_count)
  );

  circuit_eval_sequencer #(
    .IO_PAIRS(1), .SETTLE_CYCLES(2), .NUM_VECTORS(2)
  ) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .seed(seed),
    .dut_in(dut_in2), .dut_out(dut_out2), .busy(busy2), .done(done2),
    .signature(signature2), .vec_count(vec_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t reached limit 100000", $time);
    $fatal(1);
  end

  // Reference model: queue every capture (vector, running signature, count)
  task automatic push_expected(input logic m, input logic [1:0] sd, input int n,
                               output logic [1:0] final_sig);
    logic [31:0] lf;
    logic [1:0]  v, sg, resp;
    exp_t        e;
    lf = {30'd0, sd};
    if (m == 1'b1 && sd == 2'b00) lf = 32'd1;
    v  = (m == 1'b1) ? lf[1:0] : sd;
    sg = 2'b00;
    for (int k = 0; k < n; k++) begin
      resp  = {v[1] ^ v[0], ~v[0]};
      sg    = {sg[0], sg[1]} ^ resp;
      e.vec = v;
      e.sig = sg;
      e.cnt = 3'(k + 1);
      sb_q.push_back(e);
      if (m == 1'b1) begin
        lf = {lf[30:0], lf[31] ^ lf[21] ^ lf[1] ^ lf[0]};
        v  = lf[1:0];
      end else begin
        v = v + 2'b01;
      end
    end
    final_sig = sg;
  endtask

  // Capture monitor: pops one expectation whenever vec_count steps by one
  initial begin : monitor
    logic [1:0] prev_in;
    logic [2:0] prev_cnt;
    exp_t       e;
    prev_in  = 2'b00;
    prev_cnt = 3'd0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && vec_count === prev_cnt + 3'd1) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          $display("FAIL capture_unexpected: vec_count=%0d dut_in=%b, nothing expected",
                   vec_count, prev_in);
        end else begin
          e = sb_q.pop_front();
          if (prev_in !== e.vec || signature !== e.sig || vec_count !== e.cnt)
            $display("FAIL capture: got vec=%b sig=%b cnt=%0d, expected vec=%b sig=%b cnt=%0d",
                     prev_in, signature, vec_count, e.vec, e.sig, e.cnt);
          else
            n_pass++;
        end
      end
      prev_in  = dut_in;
      prev_cnt = vec_count;
    end
  end

  // Start a run and wait (bounded) for done; lat counts negedges after the start edge
  task automatic do_run(input logic m, input logic [1:0] sd, input int glitch_at,
                        output int lat);
    lat = 0;
    lat2 = 0;
    @(negedge clk);
    mode = m; seed = sd; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
      start = (lat == glitch_at);
      if (lat == glitch_at) begin
        mode = ~m;
        seed = ~sd;
      end
      if (lat == 1) s2_first = dut_in2;
      if (lat == 4) s2_second = dut_in2;
      if (done2 === 1'b1) lat2 = lat;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({dut_in, signature, vec_count, busy, done} !== 9'b0)
      $display("FAIL reset_main: got in=%b sig=%b cnt=%0d busy=%b done=%b, expected all 0",
               dut_in, signature, vec_count, busy, done);
    else n_pass++;
    n_checks++;
    if ({dut_in2, signature2, vec_count2, busy2, done2} !== 8'b0)
      $display("FAIL reset_short: got in=%b sig=%b cnt=%0d, expected all 0",
               dut_in2, signature2, vec_count2);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_counter();
    logic [1:0] es;
    int lat;
    push_expected(1'b0, 2'b00, 4, es);
    do_run(1'b0, 2'b00, 0, lat);
    n_checks++;
    if (lat !== 13) $display("FAIL counter_latency: got %0d, expected 13", lat);
    else n_pass++;
    n_checks++;
    if (signature !== 2'b11) $display("FAIL counter_sig: got %b, expected 11", signature);
    else n_pass++;
    n_checks++;
    if (vec_count !== 3'd4 || busy !== 1'b0)
      $display("FAIL counter_end: got cnt=%0d busy=%b, expected cnt=4 busy=0", vec_count, busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) $display("FAIL counter_done_width: done=%b one cycle later, expected 0", done);
    else n_pass++;
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL counter_missing: %0d captures left, expected 0", sb_q.size());
    else n_pass++;
  endtask

  task automatic test_lfsr();
    int lat;
    push_expected(1'b1, 2'b01, 4, lfsr_sig_ref);
    do_run(1'b1, 2'b01, 0, lat);
    n_checks++;
    if (lat !== 13 || signature !== lfsr_sig_ref || vec_count !== 3'd4)
      $display("FAIL lfsr_end: got lat=%0d sig=%b cnt=%0d, expected lat=13 sig=%b cnt=4",
               lat, signature, vec_count, lfsr_sig_ref);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL lfsr_missing: %0d captures left, expected 0", sb_q.size());
    else n_pass++;
  endtask

  task automatic test_lfsr_zero_seed();
    logic [1:0] es;
    int lat;
    push_expected(1'b1, 2'b00, 4, es);
    do_run(1'b1, 2'b00, 0, lat);
    n_checks++;
    if (lat !== 13 || signature !== lfsr_sig_ref)
      $display("FAIL lfsr_zero_seed: got lat=%0d sig=%b, expected lat=13 sig=%b",
               lat, signature, lfsr_sig_ref);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL lfsr_zero_missing: %0d captures left, expected 0", sb_q.size());
    else n_pass++;
  endtask

  task automatic test_counter_wrap();
    logic [1:0] es;
    int lat;
    push_expected(1'b0, 2'b11, 4, es);
    do_run(1'b0, 2'b11, 0, lat);
    n_checks++;
    if (s2_first !== 2'b11 || s2_second !== 2'b00)
      $display("FAIL wrap_vectors: got %b then %b, expected 11 then 00", s2_first, s2_second);
    else n_pass++;
    n_checks++;
    if (lat2 !== 7 || signature2 !== 2'b01 || vec_count2 !== 2'd2)
      $display("FAIL wrap_short_end: got lat=%0d sig=%b cnt=%0d, expected lat=7 sig=01 cnt=2",
               lat2, signature2, vec_count2);
    else n_pass++;
    n_checks++;
    if (lat !== 13 || signature !== es)
      $display("FAIL wrap_main_end: got lat=%0d sig=%b, expected lat=13 sig=%b", lat, signature, es);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL wrap_missing: %0d captures left, expected 0", sb_q.size());
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [1:0] es;
    int cyc, lat;
    logic saw_done;
    push_expected(1'b0, 2'b00, 2, es);
    @(negedge clk);
    mode = 1'b0; seed = 2'b00; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (vec_count !== 3'd2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || vec_count !== 3'd2 || signature !== 2'b00 || dut_in !== 2'b10)
      $display("FAIL abort_state: got busy=%b cnt=%0d sig=%b in=%b, expected busy=0 cnt=2 sig=00 in=10",
               busy, vec_count, signature, dut_in);
    else n_pass++;
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0 || busy !== 1'b0 || sb_q.size() != 0)
      $display("FAIL abort_quiet: got done_seen=%b busy=%b left=%0d, expected 0 0 0",
               saw_done, busy, sb_q.size());
    else n_pass++;
    push_expected(1'b0, 2'b00, 4, es);
    do_run(1'b0, 2'b00, 0, lat);
    n_checks++;
    if (lat !== 13 || signature !== 2'b11 || vec_count !== 3'd4)
      $display("FAIL abort_rerun: got lat=%0d sig=%b cnt=%0d, expected lat=13 sig=11 cnt=4",
               lat, signature, vec_count);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_rst_and_busy_start();
    logic [1:0] es;
    int cyc, lat;
    push_expected(1'b0, 2'b10, 2, es);
    @(negedge clk);
    mode = 1'b0; seed = 2'b10; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (vec_count !== 3'd2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (signature !== es || busy !== 1'b1)
      $display("FAIL pre_rst: got sig=%b busy=%b, expected sig=%b busy=1", signature, busy, es);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({dut_in, signature, vec_count, busy, done} !== 9'b0)
      $display("FAIL rst_async: got in=%b sig=%b cnt=%0d busy=%b done=%b, expected all 0",
               dut_in, signature, vec_count, busy, done);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_no_done: got done=%b busy=%b, expected 0 0", done, busy);
    else n_pass++;
    push_expected(1'b0, 2'b00, 4, es);
    do_run(1'b0, 2'b00, 5, lat);
    n_checks++;
    if (lat !== 13 || signature !== 2'b11 || vec_count !== 3'd4)
      $display("FAIL busy_start: got lat=%0d sig=%b cnt=%0d, expected lat=13 sig=11 cnt=4",
               lat, signature, vec_count);
    else n_pass++;
    // start while in DONE must not begin a new run
    mode = 1'b0; seed = 2'b01; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || vec_count !== 3'd4 || signature !== 2'b11 || sb_q.size() != 0)
      $display("FAIL done_start: got busy=%b cnt=%0d sig=%b left=%0d, expected 0 4 11 0",
               busy, vec_count, signature, sb_q.size());
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    lat2     = 0;
    s2_first = 2'b00;
    s2_second = 2'b00;
    lfsr_sig_ref = 2'b00;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    mode  = 1'b0;
    seed  = 2'b00;
    test_reset();
    test_counter();
    test_lfsr();
    test_lfsr_zero_seed();
    test_counter_wrap();
    test_abort();
    test_rst_and_busy_start();
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
